// File: rtl/booth_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_if
// Description : Operand, ALU and result bundle of the Booth sequencer.
// Revision    : 1.0
// ============================================================================
interface booth_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [N:0]       alu_a;
    logic [N:0]       alu_b;
    logic             add_en;
    logic             sub_en;
    logic [N:0]       add_out;
    logic [N:0]       sub_out;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport slave (
        input  start, multiplicand, multiplier, add_out, sub_out,
        output alu_a, alu_b, add_en, sub_en, busy, done, product
    );

    modport master (
        output start, multiplicand, multiplier, add_out, sub_out,
        input  alu_a, alu_b, add_en, sub_en, busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_sequencer
// Description : Radix-2 Booth multiply controller driving external N+1 bit
//               adder/subtractor; one iteration per cycle, 2N-bit product.
// Revision    : 1.0
// ============================================================================
module booth_sequencer #(
    parameter int N = 8
) (
    input  logic   clk,
    input  logic   rst,
    booth_if.slave bus
);
    localparam int             CW         = $clog2(N + 1);
    localparam logic [CW-1:0]  c_cnt_init = CW'(N);
    localparam logic [CW-1:0]  c_cnt_one  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [N:0]        a_q;
    logic [N:0]        mx_q;
    logic [N-1:0]      q_q;
    logic              q1_q;
    logic [CW-1:0]     cnt_q;
    logic [2*N-1:0]    product_q;
    logic              busy_q;
    logic              done_q;

    logic              w_add_en;
    logic              w_sub_en;
    logic [N:0]        w_s;
    logic [N:0]        a_d;
    logic [N-1:0]      q_d;

    // Booth pair {Q[0], q_1}: 10 subtracts M, 01 adds M, else pass A through.
    always_comb begin
        w_add_en = (state_q == S_RUN) && !q_q[0] &&  q1_q;
        w_sub_en = (state_q == S_RUN) &&  q_q[0] && !q1_q;
        w_s      = a_q;
        if (w_sub_en) begin
            w_s = bus.sub_out;
        end else if (w_add_en) begin
            w_s = bus.add_out;
        end
        a_d = {w_s[N], w_s[N:1]};
        q_d = {w_s[0], q_q[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            mx_q      <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= '0;
                        mx_q    <= {bus.multiplicand[N-1], bus.multiplicand};
                        q_q     <= bus.multiplier;
                        q1_q    <= 1'b0;
                        cnt_q   <= c_cnt_init;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    q1_q  <= q_q[0];
                    cnt_q <= cnt_q - c_cnt_one;
                    if (cnt_q == c_cnt_one) begin
                        product_q <= {a_d[N-1:0], q_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a   = a_q;
    assign bus.alu_b   = mx_q;
    assign bus.add_en  = w_add_en;
    assign bus.sub_en  = w_sub_en;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
`default_nettype wire

// File: doc/booth_sequencer.md
# booth_sequencer

Sequential radix-2 Booth controller and register file for the signed multiplier processor. It accepts two signed N-bit operands and runs N add/subtract-and-shift iterations, returning a signed 2N-bit product. It sits directly upstream of the adder and subtractor blocks: it drives their operands and enables, and consumes their results in the same cycle. The adder and subtractor are instantiated by the parent at width N+1.

## Interface
- N, default 8, operand width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  N  signed M, captured on accepted start
- multiplier  input  N  signed Q, captured on accepted start
- alu_a  output  N+1  accumulator A (registered), to adder/subtractor input a
- alu_b  output  N+1  sign-extended M (registered), to adder/subtractor input b
- add_en  output  1  combinational enable for the adder
- sub_en  output  1  combinational enable for the subtractor
- add_out  input  N+1  adder result, a+b
- sub_out  input  N+1  subtractor result, a−b
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when the product becomes valid
- product  output  2N  signed result, held until the next completion or reset

## Operation
- Registers:
  - A (N+1 bits)
  - Mx (N+1 bits; M sign-extended)
  - Q (N bits)
  - q_1 (1 bit)
  - cnt (covers 0..N)
  - product (2N bits)
  - state
- States:
  - IDLE: wait for start. When start=1, load A=0, Mx=sext(multiplicand), Q=multiplier, q_1=0, cnt=N, and go to RUN.
  - RUN: each cycle, select from {Q[0],q_1}:
    - 00 or 11: no enable; S=A.
    - 10: sub_en=1; S=sub_out.
    - 01: add_en=1; S=add_out.
    - On the clock edge: {A,Q,q_1} ← arithmetic right shift of {S,Q,q_1} by 1. Bit A[N] replicates S[N]. Then cnt ← cnt−1.
    - When cnt=1 at the edge, also write product ← {A_new[N-1:0], Q_new} and go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Enables:
  - add_en and sub_en are never both 1.
  - Both are 0 outside RUN.
  - add_out and sub_out are used only in cycles where the matching enable is 1. The downstream blocks hold their last value otherwise, and those held values are don't-care.
- Width rules:
  - The N+1-bit accumulator makes multiplicand = −2^(N−1) exact.
  - Every N-bit signed pair gives a mathematically exact 2N-bit signed product.
- Boundary conditions:
  - start while RUN or DONE is ignored; operands are not re-captured.
  - start held high continuously re-triggers one cycle after DONE, in IDLE.
  - Multiplier = 0: N RUN cycles with no enables; product = 0.
  - The operand inputs may change freely after the start cycle.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE
  - A, Mx, Q, q_1, cnt, product all 0
  - busy=0, done=0, add_en=0, sub_en=0, alu_a=0, alu_b=0
  - Reset mid-multiply abandons the operation; no done pulse follows.
- Latency. Let edge 0 be the edge that samples start=1 in IDLE.
  - busy is high from after edge 0 through edge N (N cycles).
  - product updates at edge N.
  - done is high for the single cycle between edge N and edge N+1.
  - The next start can be accepted at edge N+2 (IDLE cycle).
  - Throughput is one multiply per N+2 cycles.
- product is registered and changes only at the completion edge or on reset.

## Test plan
- N=8, M=3, Q=−4 → after N+1 cycles done pulses once; product=16'hFFF4 (−12); busy high for exactly 8 cycles.
- M=−128, Q=−128 → product=16'h4000 (16384). M=−128, Q=127 → product=16'hC080 (−16256). These confirm the N+1-bit accumulator.
- M=5, Q=8'h55 → add_en and sub_en alternate, with sub_en on the first RUN cycle; they are never simultaneous; product=16'h01A9 (425).
- M=7, Q=0 → no enables during RUN; product=0; done still at cycle N+1. M=0, Q=−1 → product=0.
- start pulsed at RUN cycles 3 and 8 and during DONE, with different operands → ignored; product equals the first operands' result. Then start held high → back-to-back multiplies at an N+2 cycle period.
- rst asserted asynchronously in RUN cycle 4 → all outputs 0 immediately, with no done pulse. A fresh start after release completes correctly (e.g. −7×9 → 16'hFFC1).
